// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/result bundle for the bit-serial adder controller.
//               Carries the start request and operands toward the adder, and
//               the busy/done status and registered result back.
//   start  master->slave  request to begin an addition
//   a_in   master->slave  operand A, WIDTH bits
//   b_in   master->slave  operand B, WIDTH bits
//   c_in   master->slave  carry-in
//   busy   slave->master  operation in progress (RUN or DONE)
//   done   slave->master  one-cycle result-valid pulse
//   sum    slave->master  registered sum, WIDTH bits
//   c_out  slave->master  registered final carry
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;

   modport master (
      output start, a_in, b_in, c_in,
      input  busy, done, sum, c_out
   );

   modport slave (
      input  start, a_in, b_in, c_in,
      output busy, done, sum, c_out
   );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl (with helper cell fa_cell)
// Description : Bit-serial adder controller. One 1-bit full-adder cell is
//               stepped LSB-first over WIDTH cycles; the carry is held in a
//               register between steps. The completed sum and carry are
//               registered and flagged with a one-cycle done pulse.
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of serial_add_ctrl_if (start/a_in/b_in/c_in in,
//          busy/done/sum/c_out out)
// Parameters  : WIDTH - operand and sum width, 2..32
// Revision    : 1.0 - initial release
// ============================================================================

// 1-bit full-adder cell
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);
   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the WIDTH-1 sum bits already produced, newest at the MSB; the
   // final bit comes straight from the cell on the last step.
   logic [WIDTH-2:0] psum;
   logic [WIDTH-1:0] psum_next;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sum_r;
   logic             c_out_r;
   logic             busy_r;
   logic             done_r;
   logic             fa_s;
   logic             fa_c;

   fa_cell u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c_in  (carry_reg),
      .s     (fa_s),
      .c_out (fa_c)
   );

   assign psum_next = {fa_s, psum};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         psum      <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         sum_r     <= '0;
         c_out_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_sr      <= bus.a_in;
                  b_sr      <= bus.b_in;
                  carry_reg <= bus.c_in;
                  cnt       <= '0;
                  busy_r    <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               a_sr      <= a_sr >> 1;
               b_sr      <= b_sr >> 1;
               psum      <= psum_next[WIDTH-1:1];
               carry_reg <= fa_c;
               if (cnt == LAST) begin
                  // Final bit: publish the completed result.
                  sum_r   <= psum_next;
                  c_out_r <= fa_c;
                  done_r  <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.sum   = sum_r;
   assign bus.c_out = c_out_r;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench for serial_add_ctrl with a
//               WIDTH=8 instance and a WIDTH=2 instance. Expected results are
//               computed by plain integer addition when an operation is
//               accepted and popped from a queue when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8)) if8 ();
   serial_add_ctrl_if #(.WIDTH(2)) if2 ();

   serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_add_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   typedef struct packed {
      logic [7:0] s;
      logic       c;
   } exp_t;

   exp_t       q[$];
   int         total = 0;
   int         bad   = 0;
   logic [7:0] prev_s;
   logic       prev_c;
   int         lat;
   int         busy_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one accepting edge and record the
   // expected result.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] t;
      exp_t       e;
      if8.start = 1'b1;
      if8.a_in  = a;
      if8.b_in  = b;
      if8.c_in  = c;
      step();
      if8.start = 1'b0;
      t   = {1'b0, a} + {1'b0, b} + {8'd0, c};
      e.s = t[7:0];
      e.c = t[8];
      q.push_back(e);
      busy_n = (if8.busy === 1'b1) ? 1 : 0;
   endtask

   // Step until done (bounded), checking that the old result is held during
   // RUN; optionally scramble the operand inputs while running.
   task automatic wait_done(input string tag, input bit scramble);
      exp_t e;
      int   n = 0;
      while (if8.done !== 1'b1 && n < 40) begin
         chk({tag, "_hold"}, {23'd0, if8.c_out, if8.sum}, {23'd0, prev_c, prev_s});
         if (scramble) begin
            if8.a_in = 8'hFF;
            if8.b_in = 8'hFF;
            if8.c_in = ~if8.c_in;
         end
         step();
         n++;
         if (if8.busy === 1'b1) busy_n++;
      end
      lat = n;
      chk({tag, "_done"}, {31'd0, if8.done}, 32'd1);
      if (q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = q.pop_front();
         chk({tag, "_sum"},   {24'd0, if8.sum},   {24'd0, e.s});
         chk({tag, "_c_out"}, {31'd0, if8.c_out}, {31'd0, e.c});
         prev_s = e.s;
         prev_c = e.c;
      end
      step();
      if (if8.busy === 1'b1) busy_n++;
      chk({tag, "_done_clear"}, {31'd0, if8.done}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         t1, t2, np;
      exp_t       e;
      logic [2:0] t2w;

      rst_n     = 1'b0;
      if8.start = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.c_in = 1'b0;
      if2.start = 1'b0; if2.a_in = '0; if2.b_in = '0; if2.c_in = 1'b0;
      prev_s = 8'h00;
      prev_c = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset state
      chk("rst_busy",  {31'd0, if8.busy},  32'd0);
      chk("rst_done",  {31'd0, if8.done},  32'd0);
      chk("rst_sum",   {24'd0, if8.sum},   32'd0);
      chk("rst_c_out", {31'd0, if8.c_out}, 32'd0);

      // 0x5A + 0x3C: done is sampled WIDTH edges after the accepting edge
      // (the DONE cycle is the WIDTH+1-th cycle); busy spans 9 cycles.
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done("t1", 1'b0);
      chk("t1_latency", lat, 32'd8);
      chk("t1_busy_cycles", busy_n, 32'd9);

      // Full carry ripple, then all-ones with carry-in
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done("t2a", 1'b0);
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done("t2b", 1'b0);

      // start held high: back-to-back operations one every WIDTH+2 cycles
      if8.start = 1'b1;
      if8.a_in  = 8'h01; if8.b_in = 8'h01; if8.c_in = 1'b0;
      step();
      e.s = 8'h02; e.c = 1'b0; q.push_back(e);
      if8.a_in  = 8'h80; if8.b_in = 8'h80;
      e.s = 8'h00; e.c = 1'b1; q.push_back(e);
      t1 = -1; t2 = -1; np = 0;
      for (int i = 1; i <= 19; i++) begin
         if (i == 19) if8.start = 1'b0;
         step();
         if (if8.done === 1'b1) begin
            np++;
            if (np == 1) t1 = i;
            else if (np == 2) t2 = i;
            if (q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL t3_sb observed=empty expected=entry");
            end else begin
               e = q.pop_front();
               chk("t3_sum",   {24'd0, if8.sum},   {24'd0, e.s});
               chk("t3_c_out", {31'd0, if8.c_out}, {31'd0, e.c});
               prev_s = e.s;
               prev_c = e.c;
            end
         end
      end
      if8.start = 1'b0;
      chk("t3_pulses", np, 32'd2);
      chk("t3_gap", t2 - t1, 32'd10);
      repeat (12) step();
      chk("t3_no_extra_done", {31'd0, if8.done}, 32'd0);
      chk("t3_idle_busy", {31'd0, if8.busy}, 32'd0);
      chk("t3_sb_drained", q.size(), 32'd0);

      // Operand changes during RUN must not affect the result
      start_op(8'h12, 8'h34, 1'b0);
      wait_done("t4", 1'b1);

      // Asynchronous reset mid-RUN at cnt=4, between clock edges
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  {31'd0, if8.busy},  32'd0);
      chk("arst_done",  {31'd0, if8.done},  32'd0);
      chk("arst_sum",   {24'd0, if8.sum},   32'd0);
      chk("arst_c_out", {31'd0, if8.c_out}, 32'd0);
      void'(q.pop_back());
      prev_s = 8'h00;
      prev_c = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      start_op(8'h0F, 8'hF1, 1'b0);
      wait_done("t5", 1'b0);

      // WIDTH=2 instance: 3 + 3 + 1
      t2w = 3'd3 + 3'd3 + 3'd1;
      if2.start = 1'b1;
      if2.a_in  = 2'd3; if2.b_in = 2'd3; if2.c_in = 1'b1;
      step();
      if2.start = 1'b0;
      np = 0;
      while (if2.done !== 1'b1 && np < 10) begin
         step();
         np++;
      end
      chk("w2_latency", np, 32'd2);
      chk("w2_done",  {31'd0, if2.done},  32'd1);
      chk("w2_sum",   {30'd0, if2.sum},   {30'd0, t2w[1:0]});
      chk("w2_c_out", {31'd0, if2.c_out}, {31'd0, t2w[2]});
      step();
      chk("w2_done_clear", {31'd0, if2.done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It time-multiplexes one instance of the team's 1-bit full-adder cell (inputs a, b, c_in; outputs s, c_out) across WIDTH cycles to add two WIDTH-bit operands.
- It captures the operands on a start request, steps the cell LSB-first while holding the carry in a register, then presents the registered result with a one-cycle done pulse.
- It is intended for area-constrained paths where latency is acceptable.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..32.

Ports:
- clk    input   1      single clock; all state updates on its rising edge
- rst_n  input   1      asynchronous, active-low reset
- start  input   1      request to begin an addition; sampled only in IDLE
- a_in   input   WIDTH  operand A; captured on the accepting edge
- b_in   input   WIDTH  operand B; captured on the accepting edge
- c_in   input   1      carry-in; captured on the accepting edge
- busy   output  1      high in RUN and DONE
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  registered sum; held until the next result
- c_out  output  1      registered final carry; held with sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0. Internal shift registers, carry register and bit counter also reset to 0.
- Reset mid-operation: immediate abort to the reset values. No partial result is exposed.

State machine:
- IDLE:
  - start=1 at edge E0 loads the A and B shift registers from a_in and b_in, sets carry_reg to c_in and cnt to 0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge feeds bit 0 of the A shift register, bit 0 of the B shift register, and carry_reg into the full-adder cell.
  - The cell's s is shifted into the MSB of a partial-sum shift register. The A and B registers shift right by 1.
  - carry_reg takes the cell's c_out; cnt increments.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH), the final bit is processed, sum and c_out are loaded from the completed partial sum and carry, and the state moves to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - The next edge returns to IDLE with done=0.

Timing and handshake:
- Latency: start accepted at E0; done high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after acceptance. Next acceptance is possible at E_(WIDTH+2).
- With start held high, one addition completes every WIDTH+2 cycles.
- busy goes high the cycle after E0 and stays high through the DONE cycle.
- start in RUN or DONE is ignored; it is not queued.
- a_in, b_in and c_in are don't-care outside the accepting edge. Changes during RUN do not affect the result.
- sum and c_out change only on entry to DONE or on reset. They hold the old result throughout RUN.

Arithmetic:
- {c_out, sum} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1) with no truncation of the carry.
- The carry from bit i feeds bit i+1 via carry_reg.
- cnt width is clog2(WIDTH). No cnt wrap occurs because the exit happens at WIDTH-1.

Test Plan:
- WIDTH=8, a_in=0x5A, b_in=0x3C, c_in=0, one-cycle start -> done pulse 9 cycles after the accepting edge; sum=0x96, c_out=0; busy high for exactly 9 cycles.
- a_in=0xFF, b_in=0x01, c_in=0 -> sum=0x00, c_out=1 (full carry ripple through all 8 steps). Then a_in=0xFF, b_in=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- start held high continuously with operands 0x01+0x01, then 0x80+0x80 presented on the next accepting edge -> done pulses exactly 10 cycles apart. Results: 0x02/0, then 0x00/1. Extra start cycles during RUN/DONE produce no extra operations.
- Accept 0x12+0x34, then change a_in/b_in to 0xFF every cycle during RUN -> sum=0x46, c_out=0. sum holds the previous result (0x00 after reset) until done.
- Assert rst_n=0 asynchronously mid-RUN (between clock edges, at cnt=4) -> busy, done, sum and c_out go to 0 immediately without waiting for a clock edge. After release, IDLE accepts a new start and 0x0F+0xF1, c_in=0 gives sum=0x00, c_out=1.
- WIDTH=2 instance: a_in=3, b_in=3, c_in=1 -> done 3 cycles after acceptance, sum=3, c_out=1.
